// File: rtl/code_serializer_if.sv
// Producer handshake and serial-output bundle for code_serializer.
interface code_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] code_in;
  logic             code_valid;
  logic             code_ready;
  logic             seq;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output code_in, code_valid,
    input  code_ready, seq, bit_valid, frame_start, busy
  );

  modport slave (
    input  code_in, code_valid,
    output code_ready, seq, bit_valid, frame_start, busy
  );
endinterface

// File: rtl/code_serializer.sv
// Parallel codes -> MSB-first bits on seq (BIT_DIV clocks/bit, GAP zero bits after each word); first bit one clock after
// transfer from the one-word hold register, code_ready = hold empty. CODE_SERIALIZER_PARITY_EN appends an even-parity bit.
module code_serializer #(
  parameter int WIDTH   = 4,
  parameter int BIT_DIV = 1,
  parameter int GAP     = 2
) (
  input  logic             clock,
  input  logic             resetphase_n,
  code_serializer_if.slave bus
);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
`ifdef CODE_SERIALIZER_PARITY_EN
    ST_PAR,
`endif
    ST_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
  logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
`ifdef CODE_SERIALIZER_PARITY_EN
  logic             r_par, w_par_nxt;
`endif
  logic             r_seq, r_bit_valid, r_frame_start, r_busy;
  logic             w_seq_nxt, w_bv_nxt, w_fs_nxt;
  logic             w_accept, w_xfer, w_div_last, w_word_done, w_tail;

  assign w_accept   = bus.code_valid & ~r_hold_full;
  assign w_div_last = (r_div_cnt == DIV_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_div_nxt   = '0;
    w_xfer      = 1'b0;
    w_word_done = 1'b0;
    w_tail      = 1'b0;

    if (r_state != ST_IDLE && !w_div_last)
      w_div_nxt = r_div_cnt + 1'b1;

    case (r_state)
      ST_IDLE: w_xfer = r_hold_full;
      ST_SHIFT: begin
        if (w_div_last) begin
          if (r_bit_cnt == BIT_LAST) begin
`ifdef CODE_SERIALIZER_PARITY_EN
            w_state_nxt = ST_PAR;
`else
            w_word_done = 1'b1;
`endif
          end else begin
            w_bit_nxt   = r_bit_cnt + 1'b1;
            w_shift_nxt = r_shift << 1;
          end
        end
      end
`ifdef CODE_SERIALIZER_PARITY_EN
      ST_PAR: w_word_done = w_div_last;
`endif
      ST_GAP: begin
        if (w_div_last) begin
          if (r_gap_cnt == GAP_LAST) w_tail = 1'b1;
          else                       w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_word_done) begin
      if (GAP > 0) begin
        w_state_nxt = ST_GAP;
        w_gap_nxt   = '0;
      end else begin
        w_tail = 1'b1;
      end
    end

    // End of a frame chains straight into the held word, so GAP=0 runs back-to-back.
    if (w_tail) begin
      if (r_hold_full) w_xfer      = 1'b1;
      else             w_state_nxt = ST_IDLE;
    end

    if (w_xfer) begin
      w_state_nxt = ST_SHIFT;
      w_shift_nxt = r_hold;
      w_bit_nxt   = '0;
    end

    w_hold_full_nxt = w_xfer ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

    w_seq_nxt = (w_state_nxt == ST_SHIFT) & w_shift_nxt[WIDTH-1];
    w_bv_nxt  = (w_state_nxt == ST_SHIFT);
    w_fs_nxt  = (w_state_nxt == ST_SHIFT) && (w_bit_nxt == '0);
`ifdef CODE_SERIALIZER_PARITY_EN
    w_par_nxt = w_xfer ? ^r_hold : r_par;
    if (w_state_nxt == ST_PAR) begin
      w_seq_nxt = w_par_nxt;
      w_bv_nxt  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge resetphase_n) begin
    if (!resetphase_n) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_div_cnt     <= '0;
      r_gap_cnt     <= '0;
`ifdef CODE_SERIALIZER_PARITY_EN
      r_par         <= 1'b0;
`endif
      r_seq         <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_full   <= w_hold_full_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_div_cnt     <= w_div_nxt;
      r_gap_cnt     <= w_gap_nxt;
`ifdef CODE_SERIALIZER_PARITY_EN
      r_par         <= w_par_nxt;
`endif
      r_seq         <= w_seq_nxt;
      r_bit_valid   <= w_bv_nxt;
      r_frame_start <= w_fs_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      if (w_accept) r_hold <= bus.code_in;
    end
  end

  assign bus.code_ready  = ~r_hold_full;
  assign bus.seq         = r_seq;
  assign bus.bit_valid   = r_bit_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: instance 0 uses defaults, instance 1 uses BIT_DIV=3, GAP=0.
// A frame-expansion model predicts every output cycle; directed scenarios pin it with literal waveforms.
module tb_code_serializer;
`ifdef CODE_SERIALIZER_PARITY_EN
  localparam int P = 1;
  localparam logic [7:0]  SW0_SEQ  = 8'b10111000;
  localparam logic [7:0]  SW0_BV   = 8'b11111000;
  localparam logic [7:0]  SW0_BUSY = 8'b11111110;
  localparam logic [15:0] SW1_SEQ  = 16'b1110001111111110;
  localparam logic [15:0] SW1_BV   = 16'b1111111111111110;
  localparam logic [15:0] SW1_BUSY = 16'b1111111111111110;
  localparam logic [8:0]  B2B_RDY  = 9'b010000001;
`else
  localparam int P = 0;
  localparam logic [7:0]  SW0_SEQ  = 8'b10110000;
  localparam logic [7:0]  SW0_BV   = 8'b11110000;
  localparam logic [7:0]  SW0_BUSY = 8'b11111100;
  localparam logic [15:0] SW1_SEQ  = 16'b1110001111110000;
  localparam logic [15:0] SW1_BV   = 16'b1111111111110000;
  localparam logic [15:0] SW1_BUSY = 16'b1111111111110000;
  localparam logic [7:0]  B2B_RDY  = 8'b01000001;
`endif
  localparam logic [7:0]  SW0_FS = 8'b10000000;
  localparam logic [15:0] SW1_FS = 16'b1110000000000000;
  localparam int B2B = 7 + P;

  logic       clock = 1'b0;
  logic       resetphase_n = 1'b0;
  logic [3:0] din [2] = '{4'd0, 4'd0};
  logic       vld [2] = '{1'b0, 1'b0};

  code_serializer_if #(.WIDTH(4)) bus0 ();
  code_serializer_if #(.WIDTH(4)) bus1 ();
  assign bus0.code_in = din[0];
  assign bus0.code_valid = vld[0];
  assign bus1.code_in = din[1];
  assign bus1.code_valid = vld[1];

  code_serializer #(.WIDTH(4), .BIT_DIV(1), .GAP(2)) dut0 (
    .clock(clock), .resetphase_n(resetphase_n), .bus(bus0.slave));
  code_serializer #(.WIDTH(4), .BIT_DIV(3), .GAP(0)) dut1 (
    .clock(clock), .resetphase_n(resetphase_n), .bus(bus1.slave));

  always #5 clock = ~clock;

  // Model entry per cycle: {busy, frame_start, bit_valid, seq}.
  logic [3:0] fq [2][$];
  logic       m_full [2] = '{1'b0, 1'b0};
  logic       m_acc  [2] = '{1'b0, 1'b0};
  logic [3:0] m_hold [2] = '{4'd0, 4'd0};
  logic [3:0] m_cur  [2] = '{4'd0, 4'd0};

  function automatic int div_of(input int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int gap_of(input int k); return (k == 0) ? 2 : 0; endfunction

  task automatic push_frame(input int k, input logic [3:0] w);
    for (int b = 3; b >= 0; b--)
      for (int d = 0; d < div_of(k); d++) fq[k].push_back({1'b1, b == 3, 1'b1, w[b]});
    for (int p = 0; p < P; p++)
      for (int d = 0; d < div_of(k); d++) fq[k].push_back({3'b101, ^w});
    for (int g = 0; g < gap_of(k) * div_of(k); g++) fq[k].push_back(4'b1000);
  endtask

  initial forever begin
    @(posedge clock or negedge resetphase_n);
    if (!resetphase_n) begin
      for (int k = 0; k < 2; k++) begin
        fq[k].delete();
        m_full[k] = 1'b0;
        m_acc[k]  = 1'b0;
        m_cur[k]  = 4'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = vld[k] && !m_full[k];
        if (fq[k].size() == 0 && m_full[k]) begin
          push_frame(k, m_hold[k]);
          m_full[k] = 1'b0;
        end
        m_cur[k] = (fq[k].size() != 0) ? fq[k].pop_front() : 4'b0;
        if (m_acc[k]) begin
          m_full[k] = 1'b1;
          m_hold[k] = din[k];
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic [4:0] tr [2][20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // {code_ready, busy, frame_start, bit_valid, seq}
  function automatic logic [4:0] act(input int k);
    if (k == 0) return {bus0.code_ready, bus0.busy, bus0.frame_start, bus0.bit_valid, bus0.seq};
    return {bus1.code_ready, bus1.busy, bus1.frame_start, bus1.bit_valid, bus1.seq};
  endfunction

  function automatic logic [31:0] fld(input int k, input int b, input int lo, input int hi);
    logic [31:0] v = '0;
    for (int c = lo; c <= hi; c++) v = {v[30:0], tr[k][c][b]};
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
    if (chk_en)
      for (int k = 0; k < 2; k++)
        check($sformatf("cyc%0d_dut%0d", cyc, k), {27'd0, act(k)}, {27'd0, ~m_full[k], m_cur[k]});
    cyc++;
  endtask

  task automatic record(input int c);
    tr[0][c] = act(0);
    tr[1][c] = act(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] seen;
    int dens;
    repeat (3) tick();
    #2;
    check("reset_dut0", {27'd0, act(0)}, 32'h10);
    check("reset_dut1", {27'd0, act(1)}, 32'h10);
    resetphase_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // single word 1011 on both instances, accepted at edge 0
    vld[0] = 1'b1; din[0] = 4'b1011;
    vld[1] = 1'b1; din[1] = 4'b1011;
    tick();
    vld[0] = 1'b0; vld[1] = 1'b0;
    record(0);
    for (int c = 1; c < 20; c++) begin tick(); record(c); end
    check("sw0_rdy_c0c1", fld(0, 4, 0, 1), 32'b01);
    check("sw0_busy_c0", fld(0, 3, 0, 0), 32'b0);
    check("sw0_seq", fld(0, 0, 1, 8), {24'd0, SW0_SEQ});
    check("sw0_bv", fld(0, 1, 1, 8), {24'd0, SW0_BV});
    check("sw0_fs", fld(0, 2, 1, 8), {24'd0, SW0_FS});
    check("sw0_busy", fld(0, 3, 1, 8), {24'd0, SW0_BUSY});
    check("slow_seq", fld(1, 0, 1, 16), {16'd0, SW1_SEQ});
    check("slow_bv", fld(1, 1, 1, 16), {16'd0, SW1_BV});
    check("slow_fs", fld(1, 2, 1, 16), {16'd0, SW1_FS});
    check("slow_busy", fld(1, 3, 1, 16), {16'd0, SW1_BUSY});

    // back-to-back: 1011 then 0110 held valid until accepted
    tick();
    vld[0] = 1'b1; din[0] = 4'b1011;
    tick(); record(0);
    din[0] = 4'b0110;
    tick(); record(1);
    tick(); record(2);
    vld[0] = 1'b0;
    for (int c = 3; c < 20; c++) begin tick(); record(c); end
    check("b2b_rdy", fld(0, 4, 0, B2B), {23'd0, B2B_RDY});
    check("b2b_seq", fld(0, 0, B2B, B2B + 3), 32'b0110);
    check("b2b_fs", fld(0, 2, B2B, B2B + 3), 32'b1000);
    check("b2b_bv", fld(0, 1, B2B, B2B + 3), 32'b1111);

    // reset mid-word with a second word held
    tick();
    vld[0] = 1'b1; din[0] = 4'b1011;
    tick();
    din[0] = 4'b0110;
    tick();
    check("rmw_seq_c1", {31'd0, bus0.seq}, 32'd1);
    tick();
    vld[0] = 1'b0;
    check("rmw_rdy_c2", {31'd0, bus0.code_ready}, 32'd0);
    #2 resetphase_n = 1'b0;
    #1 check("rmw_async", {27'd0, act(0)}, 32'h10);
    #1 resetphase_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen = seen | {~bus0.code_ready, bus0.busy, bus0.frame_start, bus0.bit_valid, bus0.seq};
    end
    check("rmw_quiet", {27'd0, seen}, 32'd0);

    // randomized traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 4000; i++) begin
      tick();
      dens = (i < 1500) ? 85 : ((i < 3000) ? 35 : 100);
      for (int k = 0; k < 2; k++) begin
        if (!(vld[k] && !m_acc[k])) begin
          vld[k] = ($urandom_range(0, 99) < dens);
          din[k] = 4'($urandom);
        end
      end
      if (i % 900 == 450) begin
        #2 resetphase_n = 1'b0;
        #2 resetphase_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
